// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and pipeline-register controls
// shared by the Y86-64 pipeline control unit and its driver.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic [3:0]       D_icode;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic [3:0]       E_icode;
   logic [3:0]       E_dstM;
   logic             e_Cnd;
   logic [3:0]       M_icode;
   logic [3:0]       m_stat;
   logic [3:0]       W_icode;
   logic [3:0]       W_stat;
   logic             F_stall;
   logic             D_stall;
   logic             D_bubble;
   logic             E_bubble;
   logic             M_bubble;
   logic             W_stall;
   logic             running;
   logic [3:0]       proc_stat;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] retire_cnt;
   logic [CNT_W-1:0] hazard_cnt;

   modport master (
      output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
      output e_Cnd, M_icode, m_stat, W_icode, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
      input  running, proc_stat, cycle_cnt, retire_cnt, hazard_cnt
   );

   modport slave (
      input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
      input  e_Cnd, M_icode, m_stat, W_icode, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
      output running, proc_stat, cycle_cnt, retire_cnt, hazard_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble generation, IDLE/RUN/HALT sequencing
// and saturating performance counters for the 5-stage Y86-64 core.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input logic        clock,
   input logic        reset,
   pipe_ctrl_if.slave bus
);
   localparam logic [3:0] AOK    = 4'b1000;
   localparam logic [3:0] NONE   = 4'hF;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] POPQ   = 4'hB;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             running_q;
   logic [3:0]       proc_stat_q;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] hz_q, hz_d;

   logic lu, ret, mis, excM, excW, in_run;

   // Hazard terms straight from the stage registers
   always_comb begin
      lu   = (bus.E_icode == MRMOVQ || bus.E_icode == POPQ) &&
             (bus.E_dstM != NONE) &&
             (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
      ret  = (bus.D_icode == RET) || (bus.E_icode == RET) ||
             (bus.M_icode == RET);
      mis  = (bus.E_icode == JXX) && !bus.e_Cnd;
      excM = (bus.m_stat != AOK);
      excW = (bus.W_stat != AOK);
      in_run = (state_q == S_RUN);
   end

   // Pipeline register controls; frozen pipe outside RUN
   always_comb begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.D_bubble = 1'b0;
      bus.E_bubble = 1'b1;
      bus.M_bubble = 1'b1;
      bus.W_stall  = 1'b1;
      if (in_run) begin
         bus.F_stall  = lu | ret;
         bus.D_stall  = lu;
         bus.D_bubble = mis | (ret & ~lu);
         bus.E_bubble = mis | lu;
         bus.M_bubble = excM | excW;
         bus.W_stall  = excW;
      end
   end

   // Next state: HALT is sticky until reset
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (excW) state_d = S_HALT;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // State register with registered running flag and final status
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         running_q   <= 1'b0;
         proc_stat_q <= AOK;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == S_RUN);
         if (in_run && excW) proc_stat_q <= bus.W_stat;
      end
   end

   // Saturating increments, only while running
   always_comb begin
      cyc_d = cyc_q;
      ret_d = ret_q;
      hz_d  = hz_q;
      if (in_run) begin
         if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
         if (bus.W_icode != NOP && !excW && ret_q != '1)
            ret_d = ret_q + CNT_W'(1);
         if ((lu || ret) && hz_q != '1) hz_d = hz_q + CNT_W'(1);
      end
   end

   // Performance counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= '0;
         ret_q <= '0;
         hz_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
         hz_q  <= hz_d;
      end
   end

   assign bus.running    = running_q;
   assign bus.proc_stat  = proc_stat_q;
   assign bus.cycle_cnt  = cyc_q;
   assign bus.retire_cnt = ret_q;
   assign bus.hazard_cnt = hz_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios for pipe_ctrl, including a
// 4-bit counter instance for saturation.
module tb_pipe_ctrl;
   logic clk;
   logic rst;
   logic rst2;
   int   checks;
   int   failures;
   int   exp_cyc;
   int   exp_hz;
   int   exp_ret;
   bit   in_run;

   pipe_ctrl_if #(.CNT_W(32)) b();
   pipe_ctrl_if #(.CNT_W(4))  s();

   pipe_ctrl #(.CNT_W(32)) u_dut (.clock(clk), .reset(rst), .bus(b));
   pipe_ctrl #(.CNT_W(4))  u_sat (.clock(clk), .reset(rst2), .bus(s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] ctl();
      return {b.F_stall, b.D_stall, b.D_bubble,
              b.E_bubble, b.M_bubble, b.W_stall};
   endfunction

   task automatic defaults();
      b.start = 0; b.D_icode = 4'h1; b.d_srcA = 4'hF; b.d_srcB = 4'hF;
      b.E_icode = 4'h1; b.E_dstM = 4'hF; b.e_Cnd = 1'b1;
      b.M_icode = 4'h1; b.m_stat = 4'b1000;
      b.W_icode = 4'h1; b.W_stat = 4'b1000;
   endtask

   task automatic sdefaults();
      s.start = 0; s.D_icode = 4'h1; s.d_srcA = 4'hF; s.d_srcB = 4'hF;
      s.E_icode = 4'h1; s.E_dstM = 4'hF; s.e_Cnd = 1'b1;
      s.M_icode = 4'h1; s.m_stat = 4'b1000;
      s.W_icode = 4'h1; s.W_stat = 4'b1000;
   endtask

   task automatic tick();
      @(posedge clk);
      if (in_run) exp_cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1; defaults();
      tick(); tick();
      rst = 0; #1;
      checks++; if (b.running !== 1'b0) begin failures++;
         $display("FAIL reset_running got=%0b exp=0", b.running); end
      checks++; if (b.proc_stat !== 4'b1000) begin failures++;
         $display("FAIL reset_stat got=%b exp=1000", b.proc_stat); end
      checks++; if ({b.cycle_cnt, b.retire_cnt, b.hazard_cnt} !== 96'd0) begin
         failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0",
            b.cycle_cnt, b.retire_cnt, b.hazard_cnt); end
      checks++; if (ctl() !== 6'b110111) begin failures++;
         $display("FAIL idle_ctl got=%b exp=110111", ctl()); end
   endtask

   task automatic test_start();
      b.start = 1; #1;
      checks++; if (b.running !== 1'b0) begin failures++;
         $display("FAIL start_same_cycle got=%0b exp=0", b.running); end
      tick();
      b.start = 0; in_run = 1; #1;
      checks++; if (b.running !== 1'b1) begin failures++;
         $display("FAIL start_running got=%0b exp=1", b.running); end
      checks++; if (ctl() !== 6'b000000) begin failures++;
         $display("FAIL run_ctl got=%b exp=000000", ctl()); end
      for (int i = 0; i < 5; i++) tick();
      #1;
      checks++; if (b.cycle_cnt !== 32'd5) begin failures++;
         $display("FAIL cycle5 got=%0d exp=5", b.cycle_cnt); end
      checks++; if (b.retire_cnt !== 32'd0 || b.hazard_cnt !== 32'd0) begin
         failures++; $display("FAIL nop_cnt got=%0d/%0d exp=0/0",
            b.retire_cnt, b.hazard_cnt); end
   endtask

   task automatic test_load_use();
      b.E_icode = 4'h5; b.E_dstM = 4'h3; b.d_srcA = 4'h3; #1;
      checks++; if (ctl() !== 6'b110100) begin failures++;
         $display("FAIL lu_srcA got=%b exp=110100", ctl()); end
      tick(); exp_hz++;
      b.E_icode = 4'hB; b.d_srcA = 4'hF; b.d_srcB = 4'h3; #1;
      checks++; if (ctl() !== 6'b110100) begin failures++;
         $display("FAIL lu_popq_srcB got=%b exp=110100", ctl()); end
      tick(); exp_hz++;
      b.E_icode = 4'h5; b.E_dstM = 4'hF; b.d_srcB = 4'hF; #1;
      checks++; if (ctl() !== 6'b000000) begin failures++;
         $display("FAIL lu_none_reg got=%b exp=000000", ctl()); end
      tick();
      defaults(); #1;
      checks++; if (b.hazard_cnt !== 32'(exp_hz)) begin failures++;
         $display("FAIL lu_hz got=%0d exp=%0d", b.hazard_cnt, exp_hz); end
   endtask

   task automatic test_mispredict();
      b.E_icode = 4'h7; b.e_Cnd = 1'b0; #1;
      checks++; if (ctl() !== 6'b001100) begin failures++;
         $display("FAIL mis_ctl got=%b exp=001100", ctl()); end
      tick();
      b.e_Cnd = 1'b1; #1;
      checks++; if (ctl() !== 6'b000000) begin failures++;
         $display("FAIL jxx_taken got=%b exp=000000", ctl()); end
      tick();
      defaults();
   endtask

   task automatic test_ret();
      b.D_icode = 4'h9; #1;
      checks++; if (ctl() !== 6'b101000) begin failures++;
         $display("FAIL ret_D got=%b exp=101000", ctl()); end
      tick();
      b.D_icode = 4'h1; b.E_icode = 4'h9; #1;
      checks++; if (ctl() !== 6'b101000) begin failures++;
         $display("FAIL ret_E got=%b exp=101000", ctl()); end
      tick();
      b.E_icode = 4'h1; b.M_icode = 4'h9; #1;
      checks++; if (ctl() !== 6'b101000) begin failures++;
         $display("FAIL ret_M got=%b exp=101000", ctl()); end
      tick(); exp_hz += 3;
      b.M_icode = 4'h1; b.D_icode = 4'h9;
      b.E_icode = 4'h5; b.E_dstM = 4'h3; b.d_srcA = 4'h3; #1;
      checks++; if (ctl() !== 6'b110100) begin failures++;
         $display("FAIL ret_lu got=%b exp=110100", ctl()); end
      tick(); exp_hz++;
      defaults(); #1;
      checks++; if (b.hazard_cnt !== 32'(exp_hz)) begin failures++;
         $display("FAIL ret_hz got=%0d exp=%0d", b.hazard_cnt, exp_hz); end
   endtask

   task automatic test_retire();
      b.W_icode = 4'h2;
      for (int i = 0; i < 3; i++) tick();
      exp_ret += 3;
      defaults(); #1;
      checks++; if (b.retire_cnt !== 32'(exp_ret)) begin failures++;
         $display("FAIL retire got=%0d exp=%0d", b.retire_cnt, exp_ret); end
   endtask

   task automatic test_exception();
      b.m_stat = 4'b0010; #1;
      checks++; if (ctl() !== 6'b000010) begin failures++;
         $display("FAIL excM_ctl got=%b exp=000010", ctl()); end
      tick();
      b.m_stat = 4'b1000; b.W_stat = 4'b0010; b.W_icode = 4'h5; #1;
      checks++; if (ctl() !== 6'b000011 || b.running !== 1'b1) begin
         failures++; $display("FAIL excW_ctl got=%b/%0b exp=000011/1",
            ctl(), b.running); end
      tick(); in_run = 0;
      defaults(); #1;
      checks++; if (b.running !== 1'b0 || b.proc_stat !== 4'b0010) begin
         failures++; $display("FAIL halt got=%0b/%b exp=0/0010",
            b.running, b.proc_stat); end
      checks++; if (ctl() !== 6'b110111) begin failures++;
         $display("FAIL halt_ctl got=%b exp=110111", ctl()); end
      checks++; if (b.retire_cnt !== 32'(exp_ret)) begin failures++;
         $display("FAIL exc_retire got=%0d exp=%0d", b.retire_cnt, exp_ret); end
      checks++; if (b.cycle_cnt !== 32'(exp_cyc)) begin failures++;
         $display("FAIL halt_cyc got=%0d exp=%0d", b.cycle_cnt, exp_cyc); end
      b.start = 1; tick(); b.start = 0; tick(); #1;
      checks++; if (b.running !== 1'b0 || b.proc_stat !== 4'b0010) begin
         failures++; $display("FAIL halt_sticky got=%0b/%b exp=0/0010",
            b.running, b.proc_stat); end
      checks++; if (b.cycle_cnt !== 32'(exp_cyc)) begin failures++;
         $display("FAIL halt_freeze got=%0d exp=%0d", b.cycle_cnt, exp_cyc); end
   endtask

   task automatic test_reset_exit();
      rst = 1; tick(); rst = 0; #1;
      exp_cyc = 0; exp_hz = 0; exp_ret = 0;
      checks++; if (b.running !== 1'b0 || b.proc_stat !== 4'b1000) begin
         failures++; $display("FAIL rst_halt got=%0b/%b exp=0/1000",
            b.running, b.proc_stat); end
      checks++; if ({b.cycle_cnt, b.retire_cnt, b.hazard_cnt} !== 96'd0) begin
         failures++; $display("FAIL rst_halt_cnt got=%0d/%0d/%0d exp=0",
            b.cycle_cnt, b.retire_cnt, b.hazard_cnt); end
      rst = 1; b.start = 1; tick(); rst = 0; b.start = 0; #1;
      checks++; if (b.running !== 1'b0) begin failures++;
         $display("FAIL rst_over_start got=%0b exp=0", b.running); end
      b.start = 1; tick(); b.start = 0; in_run = 1; #1;
      checks++; if (b.running !== 1'b1) begin failures++;
         $display("FAIL restart got=%0b exp=1", b.running); end
      b.W_stat = 4'b0100; tick(); in_run = 0;
      defaults(); #1;
      checks++; if (b.proc_stat !== 4'b0100 || b.running !== 1'b0) begin
         failures++; $display("FAIL hlt_stat got=%b/%0b exp=0100/0",
            b.proc_stat, b.running); end
      checks++; if (b.cycle_cnt !== 32'(exp_cyc)) begin failures++;
         $display("FAIL hlt_cyc got=%0d exp=%0d", b.cycle_cnt, exp_cyc); end
   endtask

   task automatic test_saturation();
      rst2 = 0; s.start = 1; tick(); s.start = 0; s.W_icode = 4'h2;
      for (int i = 0; i < 20; i++) tick();
      #1;
      checks++; if (s.cycle_cnt !== 4'd15) begin failures++;
         $display("FAIL sat_cyc got=%0d exp=15", s.cycle_cnt); end
      checks++; if (s.retire_cnt !== 4'd15) begin failures++;
         $display("FAIL sat_ret got=%0d exp=15", s.retire_cnt); end
      checks++; if (s.hazard_cnt !== 4'd0) begin failures++;
         $display("FAIL sat_hz got=%0d exp=0", s.hazard_cnt); end
      rst2 = 1; tick(); rst2 = 0; sdefaults(); #1;
      checks++; if ({s.cycle_cnt, s.retire_cnt, s.running} !== 9'd0) begin
         failures++; $display("FAIL sat_rst got=%0d/%0d/%0b exp=0",
            s.cycle_cnt, s.retire_cnt, s.running); end
   endtask

   initial begin
      checks = 0; failures = 0;
      exp_cyc = 0; exp_hz = 0; exp_ret = 0; in_run = 0;
      rst = 1; rst2 = 1;
      defaults(); sdefaults();
      @(negedge clk);
      test_reset();
      test_start();
      test_load_use();
      test_mispredict();
      test_ret();
      test_retire();
      test_exception();
      test_reset_exit();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
